debounced_edge_capture: RTL and testbench



---
 rtl/debounced_edge_capture.sv | 220 ++++++++++++++++++++++
 tb/tb_debounced_edge_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounced_edge_capture.sv
`default_nettype none
// ============================================================================
// Module   : debounced_edge_capture
// Purpose  : Synchronizes an asynchronous level input, debounces it, and
//            records committed edges. Produces one-cycle rise/fall pulses,
//            sticky rise/fall flags and a saturating event counter. An
//            optional saturating glitch counter counts aborted transitions.
// Options  : GLITCH_MONITOR_EN - when defined, glitch_count counts aborted
//            transitions; otherwise glitch_count is tied to zero.
// Ports    : clk          system clock, all state updates on posedge
//            reset        synchronous active-high reset
//            din          asynchronous raw input
//            clr          synchronous clear of counters and sticky flags
//            level        debounced level
//            rise_pulse   one-cycle pulse on a committed 0->1
//            fall_pulse   one-cycle pulse on a committed 1->0
//            rise_seen    sticky: a rise occurred since the last clear
//            fall_seen    sticky: a fall occurred since the last clear
//            event_count  committed edges, saturating [CNT_W]
//            glitch_count aborted transitions, saturating [CNT_W]
// Revision : 1.0 - initial release
// ============================================================================
module debounced_edge_capture #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             clr,
  output logic             level,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic             rise_seen,
  output logic             fall_seen,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] glitch_count
);

  localparam int                c_DCW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_DCW-1:0]  c_CNT_LAST = c_DCW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_DCW-1:0]  c_CNT_ONE  = c_DCW'(1);
  localparam logic [CNT_W-1:0]  c_SAT      = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  c_ONE      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_STABLE_LO = 2'd0,
    ST_WAIT_HI   = 2'd1,
    ST_STABLE_HI = 2'd2,
    ST_WAIT_LO   = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_DCW-1:0]       r_cnt;
  logic [c_DCW-1:0]       w_cnt_nxt;
  logic                   w_commit_rise;
  logic                   w_commit_fall;
  logic                   w_commit;

  // --------------------------------------------------------------------------
  // Synchronizer: din feeds only the first flop of this chain.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Debounce FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_STABLE_LO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter holds the number of agreeing samples seen so far; the
  // sample that enters a WAIT state is the first of them, so the commit
  // happens when the DEBOUNCE_CYCLES-th agreeing sample arrives.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_commit_rise = 1'b0;
    w_commit_fall = 1'b0;
    case (r_state)
      ST_STABLE_LO: begin
        if (w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt   = ST_STABLE_HI;
            w_cnt_nxt     = '0;
            w_commit_rise = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_HI;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end
      end
      ST_WAIT_HI: begin
        if (!w_s) begin
          w_state_nxt = ST_STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = ST_STABLE_HI;
          w_cnt_nxt     = '0;
          w_commit_rise = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      ST_STABLE_HI: begin
        if (!w_s) begin
          if (DEBOUNCE_CYCLES == 1) begin
            w_state_nxt   = ST_STABLE_LO;
            w_cnt_nxt     = '0;
            w_commit_fall = 1'b1;
          end else begin
            w_state_nxt = ST_WAIT_LO;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end
      end
      ST_WAIT_LO: begin
        if (w_s) begin
          w_state_nxt = ST_STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = ST_STABLE_LO;
          w_cnt_nxt     = '0;
          w_commit_fall = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_commit = w_commit_rise | w_commit_fall;

  // --------------------------------------------------------------------------
  // Registered level and pulses (unaffected by clr)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      if (w_commit_rise) begin
        level <= 1'b1;
      end else if (w_commit_fall) begin
        level <= 1'b0;
      end
      rise_pulse <= w_commit_rise;
      fall_pulse <= w_commit_fall;
    end
  end

  // --------------------------------------------------------------------------
  // Sticky flags and event counter. A commit coincident with clr survives
  // the clear, so clr loads the commit itself rather than zero.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_seen   <= 1'b0;
      fall_seen   <= 1'b0;
      event_count <= '0;
    end else if (clr) begin
      rise_seen   <= w_commit_rise;
      fall_seen   <= w_commit_fall;
      event_count <= CNT_W'(w_commit);
    end else begin
      rise_seen <= rise_seen | w_commit_rise;
      fall_seen <= fall_seen | w_commit_fall;
      if (w_commit && (event_count != c_SAT)) begin
        event_count <= event_count + c_ONE;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Optional glitch monitor
  // --------------------------------------------------------------------------
`ifdef GLITCH_MONITOR_EN
  logic w_abort;

  assign w_abort = ((r_state == ST_WAIT_HI) && !w_s) ||
                   ((r_state == ST_WAIT_LO) &&  w_s);

  always_ff @(posedge clk) begin
    if (reset) begin
      glitch_count <= '0;
    end else if (clr) begin
      glitch_count <= CNT_W'(w_abort);
    end else if (w_abort && (glitch_count != c_SAT)) begin
      glitch_count <= glitch_count + c_ONE;
    end
  end
`else
  assign glitch_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debounced_edge_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_debounced_edge_capture
// Purpose  : Self-checking bench for debounced_edge_capture. A reference
//            model tracks the debounced level as a run of consecutive
//            synchronized samples that disagree with the current level;
//            every cycle all outputs are compared against it. Directed
//            sequences add fixed-value checks for latency, glitches,
//            saturation, clear/commit collision and reset mid-debounce.
// Revision : 1.0 - initial release
// ============================================================================
module tb_debounced_edge_capture;

  localparam int c_SYNC  = 2;
  localparam int c_DEB   = 4;
  localparam int c_CNT_W = 2;
  localparam int c_MAX   = (1 << c_CNT_W) - 1;

  logic               clk;
  logic               reset;
  logic               din;
  logic               clr;
  logic               level;
  logic               rise_pulse;
  logic               fall_pulse;
  logic               rise_seen;
  logic               fall_seen;
  logic [c_CNT_W-1:0] event_count;
  logic [c_CNT_W-1:0] glitch_count;

  int n_tests;
  int n_fail;

  // model state
  bit m_dly[$];
  bit m_level;
  int m_run;
  bit m_rp, m_fp, m_rs, m_fs;
  int m_ev, m_gl;

  debounced_edge_capture #(
    .SYNC_STAGES    (c_SYNC),
    .DEBOUNCE_CYCLES(c_DEB),
    .CNT_W          (c_CNT_W)
  ) u_dut (
    .clk         (clk),
    .reset       (reset),
    .din         (din),
    .clr         (clr),
    .level       (level),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .rise_seen   (rise_seen),
    .fall_seen   (fall_seen),
    .event_count (event_count),
    .glitch_count(glitch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: din reaches the debouncer after c_SYNC edges; the
  // level flips once c_DEB consecutive delayed samples disagree with it,
  // and a disagreeing run broken early counts as a glitch.
  task automatic model_step(input bit d, input bit c, input bit r);
    bit s;
    bit commit;
    bit abort_t;
    if (r) begin
      m_dly = {};
      for (int i = 0; i < c_SYNC; i++) m_dly.push_back(1'b0);
      m_level = 0; m_run = 0; m_rp = 0; m_fp = 0;
      m_rs = 0; m_fs = 0; m_ev = 0; m_gl = 0;
      return;
    end
    s = m_dly.pop_front();
    m_dly.push_back(d);
    commit  = 0;
    abort_t = 0;
    m_rp    = 0;
    m_fp    = 0;
    if (s != m_level) begin
      m_run++;
      if (m_run == c_DEB) begin
        m_level = s;
        m_run   = 0;
        commit  = 1;
        if (s) m_rp = 1; else m_fp = 1;
      end
    end else begin
      if (m_run > 0) abort_t = 1;
      m_run = 0;
    end
    if (c) begin
      m_ev = commit;
      m_gl = abort_t;
      m_rs = m_rp;
      m_fs = m_fp;
    end else begin
      if (commit && m_ev < c_MAX) m_ev++;
      if (abort_t && m_gl < c_MAX) m_gl++;
      m_rs = m_rs | m_rp;
      m_fs = m_fs | m_fp;
    end
  endtask

  task automatic compare_all();
    check_eq("level",      level,      m_level);
    check_eq("rise_pulse", rise_pulse, m_rp);
    check_eq("fall_pulse", fall_pulse, m_fp);
    check_eq("rise_seen",  rise_seen,  m_rs);
    check_eq("fall_seen",  fall_seen,  m_fs);
    check_eq("event_cnt",  event_count, m_ev);
`ifdef GLITCH_MONITOR_EN
    check_eq("glitch_cnt", glitch_count, m_gl);
`else
    check_eq("glitch_cnt", glitch_count, 0);
`endif
  endtask

  // Called at a negedge: drive inputs, advance one posedge, check at negedge.
  task automatic cycle(input bit d, input bit c, input bit r);
    din   = d;
    clr   = c;
    reset = r;
    @(posedge clk);
    model_step(d, c, r);
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input bit d, input int n);
    for (int i = 0; i < n; i++) cycle(d, 1'b0, 1'b0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    din     = 1'b0;
    clr     = 1'b0;
    reset   = 1'b1;
    @(negedge clk);

    // Reset and idle low
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    hold(1'b0, 20);
    check_eq("idle_level", level, 0);
    check_eq("idle_event", event_count, 0);

    // Latency: first cycle with din=1 is posedge 0; commit after posedge 5
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("lat_level", level, (i >= 5) ? 1 : 0);
      check_eq("lat_rise",  rise_pulse, (i == 5) ? 1 : 0);
    end
    check_eq("lat_event", event_count, 1);
    check_eq("lat_rseen", rise_seen, 1);

    // Short high glitch from a clean low state
    cycle(1'b0, 1'b0, 1'b1);
    hold(1'b0, 10);
    hold(1'b1, 2);
    hold(1'b0, 10);
    check_eq("gl_level", level, 0);
    check_eq("gl_event", event_count, 0);
`ifdef GLITCH_MONITOR_EN
    check_eq("gl_count", glitch_count, 1);
`else
    check_eq("gl_count", glitch_count, 0);
`endif

    // Saturation: five committed edges into a 2-bit counter, then clear
    cycle(1'b0, 1'b0, 1'b1);
    hold(1'b0, 5);
    for (int k = 0; k < 5; k++) hold((k % 2) == 0, 10);
    check_eq("sat_event", event_count, 3);
    check_eq("sat_level", level, 1);
    cycle(1'b1, 1'b1, 1'b0);
    check_eq("clr_event", event_count, 0);
    check_eq("clr_rseen", rise_seen, 0);
    check_eq("clr_fseen", fall_seen, 0);
    check_eq("clr_level", level, 1);

    // clr on the same edge as a committed fall
    hold(1'b1, 3);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    check_eq("cf_fpulse", fall_pulse, 1);
    check_eq("cf_event",  event_count, 1);
    check_eq("cf_fseen",  fall_seen, 1);
    check_eq("cf_rseen",  rise_seen, 0);

    // Reset while in WAIT_HI with two agreeing samples counted
    hold(1'b0, 10);
    hold(1'b1, 4);
    cycle(1'b1, 1'b0, 1'b1);
    check_eq("rw_level", level, 0);
    check_eq("rw_rise",  rise_pulse, 0);
    check_eq("rw_event", event_count, 0);
    check_eq("rw_glitch", glitch_count, 0);
    for (int j = 0; j < 8; j++) begin
      cycle(1'b1, 1'b0, 1'b0);
      check_eq("rw_lat", level, (j >= 5) ? 1 : 0);
    end

    // Randomized stimulus with varied run lengths, clears and rare resets
    begin
      bit d;
      int left;
      d    = 1'b1;
      left = 0;
      for (int n = 0; n < 3000; n++) begin
        if (left == 0) begin
          d    = ~d;
          left = $urandom_range(1, 12);
        end
        left--;
        cycle(d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 499) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
